// File: rtl/hk_clk_mon.sv
// hk_clk_mon: multi-channel reference-clock monitor.
// Each channel measures the clk_i-cycle spacing between toggles of a divided reference,
// checks it against an exclusive (min, max) window, applies lock/unlock hysteresis and
// keeps a sticky loss-of-lock flag that feeds a maskable, registered interrupt.
module hk_clk_mon #(
   parameter int unsigned NCH    = 2,
   parameter int unsigned CW     = 21,
   parameter int unsigned LOCK_N = 4,
   parameter int unsigned UNL_N  = 2
) (
   input  logic              clk_i,
   input  logic              pll_ff_rst,
   input  logic [NCH-1:0]    ref_tgl_i,
   input  logic [NCH-1:0]    cfg_en_i,
   input  logic [NCH*CW-1:0] cfg_min_i,
   input  logic [NCH*CW-1:0] cfg_max_i,
   input  logic [NCH-1:0]    irq_en_i,
   input  logic [NCH-1:0]    clr_i,
   output logic [NCH*CW-1:0] meas_o,
   output logic [NCH-1:0]    lock_o,
   output logic [NCH-1:0]    lol_o,
   output logic [NCH-1:0]    tmo_o,
   output logic              irq_o
);

   typedef enum logic [1:0] {StIdle, StAcq, StLocked, StLost} state_e;

   // Terminal hysteresis counts: the next qualifying evaluation completes the transition.
   localparam logic [3:0] LockLast = 4'(LOCK_N - 1);
   localparam logic [3:0] UnlLast  = 4'(UNL_N - 1);

   logic irq_q;

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [2:0]    sync_q;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] meas_q;
      logic [CW-1:0] win_min;
      logic [CW-1:0] win_max;
      logic          tgl_edge;
      logic          tmo_evt;
      logic          in_win;
      logic          good_q;
      logic          bad_q;
      logic          tmo_q;
      logic          lol_q;
      logic [3:0]    hc_q;
      logic [3:0]    hc_d;
      state_e        state_q;
      state_e        state_d;

      assign win_min  = cfg_min_i[k*CW +: CW];
      assign win_max  = cfg_max_i[k*CW +: CW];
      assign tgl_edge = sync_q[2] ^ sync_q[1];
      // An edge in the same cycle as counter overflow wins; that cycle is a normal compare.
      assign tmo_evt  = cnt_q[CW-1] & ~tgl_edge;
      assign in_win   = (cnt_q > win_min) && (cnt_q < win_max);

      // Three-flop synchroniser for the asynchronous toggle input.
      always_ff @(posedge clk_i or negedge pll_ff_rst) begin
         if (!pll_ff_rst) begin
            sync_q <= '0;
         end else begin
            sync_q <= {sync_q[1:0], ref_tgl_i[k]};
         end
      end

      // Period counter: latch and restart on an edge or on overflow, otherwise count.
      always_ff @(posedge clk_i or negedge pll_ff_rst) begin
         if (!pll_ff_rst) begin
            cnt_q  <= CW'(1);
            meas_q <= '0;
         end else if (tgl_edge || tmo_evt) begin
            cnt_q  <= CW'(1);
            meas_q <= cnt_q;
         end else begin
            cnt_q  <= cnt_q + CW'(1);
         end
      end

      // Registered evaluation; good/bad are single-cycle pulses, tmo holds the last verdict.
      always_ff @(posedge clk_i or negedge pll_ff_rst) begin
         if (!pll_ff_rst) begin
            good_q <= 1'b0;
            bad_q  <= 1'b0;
            tmo_q  <= 1'b0;
         end else begin
            good_q <= tgl_edge & in_win;
            bad_q  <= tmo_evt | (tgl_edge & ~in_win);
            if (tgl_edge || tmo_evt) begin
               tmo_q <= tmo_evt;
            end
         end
      end

      // Lock FSM state and hysteresis counter.
      always_ff @(posedge clk_i or negedge pll_ff_rst) begin
         if (!pll_ff_rst) begin
            state_q <= StIdle;
            hc_q    <= '0;
         end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
         end
      end

      // Lock FSM next state; disabling the channel overrides every transition.
      always_comb begin
         state_d = state_q;
         hc_d    = hc_q;
         unique case (state_q)
            StIdle: begin
               hc_d = '0;
               if (cfg_en_i[k]) begin
                  state_d = StAcq;
               end
            end
            StAcq: begin
               if (good_q) begin
                  if (hc_q == LockLast) begin
                     state_d = StLocked;
                     hc_d    = '0;
                  end else begin
                     hc_d = hc_q + 4'd1;
                  end
               end else if (bad_q) begin
                  hc_d = '0;
               end
            end
            StLocked: begin
               if (bad_q) begin
                  if (hc_q == UnlLast) begin
                     state_d = StLost;
                     hc_d    = '0;
                  end else begin
                     hc_d = hc_q + 4'd1;
                  end
               end else if (good_q) begin
                  hc_d = '0;
               end
            end
            StLost: begin
               state_d = StAcq;
               hc_d    = '0;
            end
            default: begin
               state_d = StIdle;
               hc_d    = '0;
            end
         endcase
         if (!cfg_en_i[k]) begin
            state_d = StIdle;
            hc_d    = '0;
         end
      end

      // Sticky loss-of-lock flag; a set in the same cycle as a clear takes priority.
      always_ff @(posedge clk_i or negedge pll_ff_rst) begin
         if (!pll_ff_rst) begin
            lol_q <= 1'b0;
         end else begin
            lol_q <= (state_q == StLost) | (lol_q & ~clr_i[k]);
         end
      end

      assign meas_o[k*CW +: CW] = meas_q;
      assign lock_o[k]          = (state_q == StLocked);
      assign lol_o[k]           = lol_q;
      assign tmo_o[k]           = tmo_q;
   end

   // Interrupt is the masked OR of the sticky flags, registered once more.
   always_ff @(posedge clk_i or negedge pll_ff_rst) begin
      if (!pll_ff_rst) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |(lol_o & irq_en_i);
      end
   end

   assign irq_o = irq_q;

endmodule

// File: tb/tb_hk_clk_mon.sv
// tb_hk_clk_mon: directed bench for hk_clk_mon with a tag/expected-value scoreboard.
module tb_hk_clk_mon;

   localparam int unsigned NCH = 2;
   localparam int unsigned CW  = 12;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH-1:0]    ref_tgl;
   logic [NCH-1:0]    cfg_en;
   logic [NCH*CW-1:0] cfg_min;
   logic [NCH*CW-1:0] cfg_max;
   logic [NCH-1:0]    irq_en;
   logic [NCH-1:0]    clr;
   logic [NCH*CW-1:0] meas_o;
   logic [NCH-1:0]    lock_o;
   logic [NCH-1:0]    lol_o;
   logic [NCH-1:0]    tmo_o;
   logic              irq;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // Toggle period per channel in clk cycles (0 stops the toggles).
   int unsigned per  [NCH];
   int unsigned gcnt [NCH];

   string       sb_tag [$];
   logic [31:0] sb_exp [$];

   int unsigned wper [4] = '{990, 1010, 991, 1009};
   logic        wexp [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

   bit hit;

   hk_clk_mon #(
      .NCH    (NCH),
      .CW     (CW),
      .LOCK_N (4),
      .UNL_N  (2)
   ) dut (
      .clk_i      (clk),
      .pll_ff_rst (rst_n),
      .ref_tgl_i  (ref_tgl),
      .cfg_en_i   (cfg_en),
      .cfg_min_i  (cfg_min),
      .cfg_max_i  (cfg_max),
      .irq_en_i   (irq_en),
      .clr_i      (clr),
      .meas_o     (meas_o),
      .lock_o     (lock_o),
      .lol_o      (lol_o),
      .tmo_o      (tmo_o),
      .irq_o      (irq)
   );

   always #5 clk = ~clk;

   // Reference toggle generator, stepped on the falling edge.
   initial begin
      ref_tgl = '0;
      for (int c = 0; c < NCH; c++) gcnt[c] = 0;
      forever begin
         @(negedge clk);
         for (int c = 0; c < NCH; c++) begin
            if (per[c] == 0) begin
               gcnt[c] = 0;
            end else begin
               gcnt[c]++;
               if (gcnt[c] >= per[c]) begin
                  ref_tgl[c] = ~ref_tgl[c];
                  gcnt[c]    = 0;
               end
            end
         end
      end
   end

   initial begin
      #1500us;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [CW-1:0] meas(input int c);
      return meas_o[c*CW +: CW];
   endfunction

   task automatic push(input string tag, input logic [31:0] v);
      sb_tag.push_back(tag);
      sb_exp.push_back(v);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      string       tag;
      logic [31:0] e;
      n_cmp++;
      if (sb_exp.size() == 0) begin
         n_err++;
         $error("FAIL sb_empty: observed %0d required a queued expectation", obs);
      end else begin
         tag = sb_tag.pop_front();
         e   = sb_exp.pop_front();
         assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, e);
         end
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_tog(input int c);
      logic prev;
      bit   seen;
      prev = ref_tgl[c];
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         #1;
         if (ref_tgl[c] !== prev) seen = 1'b1;
      end
      n_cmp++;
      assert (seen === 1'b1) else begin
         n_err++;
         $error("FAIL wait_tog%0d: observed no toggle required toggle", c);
      end
   endtask

   task automatic wait_lock(input int c, input logic v, input int budget, input string tag);
      bit got;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         #1;
         if (lock_o[c] === v) got = 1'b1;
      end
      n_cmp++;
      assert (got === 1'b1) else begin
         n_err++;
         $error("FAIL %s: observed lock=%0b after %0d cycles required %0b", tag, lock_o[c],
                budget, v);
      end
   endtask

   task automatic wait_tmo(input int c, input int budget, input string tag);
      bit got;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         #1;
         if (tmo_o[c] === 1'b1) got = 1'b1;
      end
      n_cmp++;
      assert (got === 1'b1) else begin
         n_err++;
         $error("FAIL %s: observed tmo=%0b after %0d cycles required 1", tag, tmo_o[c], budget);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      cfg_en  = '0;
      irq_en  = '0;
      clr     = '0;
      per[0]  = 0;
      per[1]  = 0;
      cfg_min = {2{12'd990}};
      cfg_max = {2{12'd1010}};
      #12;
      push("rst_meas", 0);
      push("rst_lock", 0);
      push("rst_lol", 0);
      push("rst_tmo", 0);
      push("rst_irq", 0);
      pop_chk(32'(meas_o));
      pop_chk(32'(lock_o));
      pop_chk(32'(lol_o));
      pop_chk(32'(tmo_o));
      pop_chk(32'(irq));

      @(negedge clk);
      rst_n  = 1'b1;
      per[0] = 1000;
      per[1] = 1000;
      cfg_en[1] = 1'b1;

      // ch0: enable on a toggle so the following evaluations are all 1000-cycle periods.
      wait_tog(0);
      wait_tog(0);
      wait_tog(0);
      cfg_en[0] = 1'b1;
      wait_tog(0);
      wait_tog(0);
      wait_tog(0);
      push("lock0_before_4th_eval", 0);
      push("meas0_steady", 1000);
      cyc(2);
      pop_chk(32'(lock_o[0]));
      cyc(8);
      pop_chk(32'(meas(0)));
      push("lock0_after_4th_eval", 1);
      push("lol0_steady", 0);
      pop_chk(32'(lock_o[0]));
      pop_chk(32'(lol_o[0]));

      // One long period then a good one: lock must hold.
      irq_en[0] = 1'b1;
      per[0] = 1020;
      push("meas0_long", 1020);
      push("lock0_one_bad", 1);
      wait_tog(0);
      per[0] = 1000;
      cyc(10);
      pop_chk(32'(meas(0)));
      pop_chk(32'(lock_o[0]));
      push("lock0_recovered", 1);
      wait_tog(0);
      cyc(10);
      pop_chk(32'(lock_o[0]));

      // Two consecutive long periods: loss of lock, with a clear in the LOST cycle.
      per[0] = 1020;
      push("lock0_first_of_two", 1);
      wait_tog(0);
      cyc(10);
      pop_chk(32'(lock_o[0]));
      wait_tog(0);
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         @(negedge clk);
         #1;
         if (lock_o[0] === 1'b0) hit = 1'b1;
      end
      clr[0] = 1'b1;
      push("lock0_fell", 1);
      push("lol0_in_lost", 0);
      push("irq_in_lost", 0);
      pop_chk(32'(hit));
      pop_chk(32'(lol_o[0]));
      pop_chk(32'(irq));
      cyc(1);
      clr[0] = 1'b0;
      push("lol0_set_beats_clr", 1);
      push("irq_lost_plus1", 0);
      pop_chk(32'(lol_o[0]));
      pop_chk(32'(irq));
      cyc(1);
      push("irq_lost_plus2", 1);
      pop_chk(32'(irq));
      per[0] = 1000;

      // ch1: stop toggles while locked; two timeouts cause loss of lock.
      wait_lock(1, 1'b1, 100, "lock1_initial");
      wait_tog(1);
      per[1] = 0;
      push("tmo1_not_early", 0);
      cyc(2030);
      pop_chk(32'(tmo_o[1]));
      wait_tmo(1, 100, "tmo1_first");
      push("meas1_tmo", 2048);
      push("lock1_after_one_tmo", 1);
      pop_chk(32'(meas(1)));
      cyc(3);
      pop_chk(32'(lock_o[1]));
      push("lock1_before_second_tmo", 1);
      cyc(2030);
      pop_chk(32'(lock_o[1]));
      wait_lock(1, 1'b0, 100, "unlock1_second_tmo");
      push("tmo1_second", 1);
      push("meas1_second", 2048);
      pop_chk(32'(tmo_o[1]));
      pop_chk(32'(meas(1)));
      cyc(1);
      push("lol1_set", 1);
      pop_chk(32'(lol_o[1]));

      // Window boundaries on ch0 (bounds are exclusive).
      for (int w = 0; w < 4; w++) begin
         cfg_en[0] = 1'b0;
         per[0] = wper[w];
         wait_tog(0);
         wait_tog(0);
         cfg_en[0] = 1'b1;
         push($sformatf("win_lock_%0d", wper[w]), 32'(wexp[w]));
         push($sformatf("win_meas_%0d", wper[w]), wper[w]);
         repeat (5) wait_tog(0);
         cyc(10);
         pop_chk(32'(lock_o[0]));
         pop_chk(32'(meas(0)));
      end

      // Disable while locked: IDLE next cycle, sticky flag untouched.
      cfg_en[0] = 1'b0;
      push("lock0_disabled", 0);
      push("lol0_kept", 1);
      push("irq_before_clr", 1);
      cyc(1);
      pop_chk(32'(lock_o[0]));
      pop_chk(32'(lol_o[0]));
      pop_chk(32'(irq));

      // Clear: flag drops next cycle, interrupt one cycle later.
      clr[0] = 1'b1;
      push("lol0_cleared", 0);
      push("irq_clr_plus1", 1);
      cyc(1);
      clr[0] = 1'b0;
      pop_chk(32'(lol_o[0]));
      pop_chk(32'(irq));
      push("irq_clr_plus2", 0);
      cyc(1);
      pop_chk(32'(irq));

      // Relock ch0, unmask ch1, then assert reset between clock edges.
      per[0] = 1000;
      cfg_en[0] = 1'b1;
      wait_lock(0, 1'b1, 8000, "relock0");
      irq_en[1] = 1'b1;
      push("irq_ch1", 1);
      cyc(2);
      pop_chk(32'(irq));
      #2;
      rst_n = 1'b0;
      push("arst_meas", 0);
      push("arst_lock", 0);
      push("arst_lol", 0);
      push("arst_tmo", 0);
      push("arst_irq", 0);
      #1;
      pop_chk(32'(meas_o));
      pop_chk(32'(lock_o));
      pop_chk(32'(lol_o));
      pop_chk(32'(tmo_o));
      pop_chk(32'(irq));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
